// File: rtl/craps_controller.sv
// craps_controller: game sequencer for the craps board.
//   Turns roll-button rising edges into timed dice tumbles.
//   Latches the final dice pair and applies the come-out and point rules.
//   Drives the dice values and the display clock enable.
//   Owns all game state: point, win and lose.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   roll                  debounced roll button (level; only rising edges count)
//   new_game              single-cycle pulse that abandons the current game
//   dice1_in, dice2_in    free-running dice generator values (valid range 1..6)
//   dice1, dice2          dice values to the display (0 = blank)
//   disp_en               display clock enable, high while tumbling
//   point                 established point, 0 when there is none
//   win, lose             game outcome, held until the next game starts
//   busy                  high while tumbling or evaluating
module craps_controller #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  input  logic       new_game,
  input  logic [2:0] dice1_in,
  input  logic [2:0] dice2_in,
  output logic [2:0] dice1,
  output logic [2:0] dice2,
  output logic       disp_en,
  output logic [3:0] point,
  output logic       win,
  output logic       lose,
  output logic       busy
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_COME_OUT,
    S_TUMBLE,
    S_EVAL,
    S_POINT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;   // 0 = come-out roll, 1 = point roll
  logic [CW-1:0] cnt_q, cnt_d;
  logic          roll_q;
  logic [2:0]    dice1_q, dice1_d, dice2_q, dice2_d;
  logic [3:0]    point_q, point_d;
  logic          win_q, win_d, lose_q, lose_d;
  logic          busy_q, busy_d, disp_en_q, disp_en_d;

  logic          roll_edge;
  logic          dice_ok;
  logic [3:0]    sum;

  function automatic logic die_valid(input logic [2:0] d);
    return (d != 3'd0) && (d != 3'd7);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_COME_OUT;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      roll_q    <= 1'b1;  // a button held through reset must not roll
      dice1_q   <= '0;
      dice2_q   <= '0;
      point_q   <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      busy_q    <= 1'b0;
      disp_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      roll_q    <= roll;
      dice1_q   <= dice1_d;
      dice2_q   <= dice2_d;
      point_q   <= point_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      busy_q    <= busy_d;
      disp_en_q <= disp_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    dice1_d   = dice1_q;
    dice2_d   = dice2_q;
    point_d   = point_q;
    win_d     = win_q;
    lose_d    = lose_q;
    roll_edge = roll & ~roll_q;
    dice_ok   = die_valid(dice1_in) && die_valid(dice2_in);
    sum       = {1'b0, dice1_q} + {1'b0, dice2_q};

    if (new_game) begin
      state_d = S_COME_OUT;
      phase_d = 1'b0;
      cnt_d   = '0;
      dice1_d = '0;
      dice2_d = '0;
      point_d = '0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_COME_OUT: begin
          if (roll_edge) begin
            state_d = S_TUMBLE;
            phase_d = 1'b0;
          end
        end
        S_TUMBLE: begin
          dice1_d = dice1_in;
          dice2_d = dice2_in;
          // At the settle point the counter holds until a valid pair shows up.
          if (cnt_q == LAST) begin
            if (dice_ok) begin
              cnt_d   = '0;
              state_d = S_EVAL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_EVAL: begin
          if (!phase_q) begin
            if (sum == 4'd7 || sum == 4'd11) begin
              win_d   = 1'b1;
              state_d = S_DONE;
            end else if (sum == 4'd2 || sum == 4'd3 || sum == 4'd12) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              point_d = sum;
              state_d = S_POINT;
            end
          end else begin
            if (sum == point_q) begin
              win_d   = 1'b1;
              state_d = S_DONE;
            end else if (sum == 4'd7) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_POINT;
            end
          end
        end
        S_POINT: begin
          if (roll_edge) begin
            state_d = S_TUMBLE;
            phase_d = 1'b1;
          end
        end
        S_DONE: begin
          if (roll_edge) begin
            win_d   = 1'b0;
            lose_d  = 1'b0;
            point_d = '0;
            state_d = S_TUMBLE;
            phase_d = 1'b0;
          end
        end
        default: state_d = S_COME_OUT;
      endcase
    end

    // Registered versions of these flags track the upcoming state.
    busy_d    = (state_d == S_TUMBLE) || (state_d == S_EVAL);
    disp_en_d = (state_d == S_TUMBLE);
  end

  assign dice1   = dice1_q;
  assign dice2   = dice2_q;
  assign disp_en = disp_en_q;
  assign point   = point_q;
  assign win     = win_q;
  assign lose    = lose_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_craps_controller.sv
module tb_craps_controller;

  logic       clock = 1'b0;
  logic       reset, roll, new_game;
  logic [2:0] dice1_in, dice2_in, dice1, dice2;
  logic       disp_en, win, lose, busy;
  logic [3:0] point;

  int vectors = 0;
  int miscompares = 0;

  craps_controller #(.SETTLE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .roll(roll), .new_game(new_game),
    .dice1_in(dice1_in), .dice2_in(dice2_in),
    .dice1(dice1), .dice2(dice2), .disp_en(disp_en),
    .point(point), .win(win), .lose(lose), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Roll edge sampled at the next edge; returns in cycle t+1.
  task automatic press();
    roll = 1'b1;
    tick();
    roll = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    roll = 1'b0;
    tick();
    new_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; roll = 1'b1; new_game = 1'b0;
    dice1_in = 3'd3; dice2_in = 3'd4;
    tick(2);
    reset = 1'b0;
    tick(3);
    vectors++;
    if ({busy, disp_en, win, lose, point, dice1, dice2} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_held outputs got busy=%b en=%b win=%b lose=%b point=%0d d=%0d,%0d expected all 0",
               busy, disp_en, win, lose, point, dice1, dice2);
    end
    roll = 1'b0;
    tick();
    roll = 1'b1;
    tick();
    vectors++;
    if ({busy, disp_en} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_then_edge busy/en got %b%b expected 11", busy, disp_en);
    end
    pulse_new_game();
    vectors++;
    if ({busy, disp_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_abort busy/en got %b%b expected 00", busy, disp_en);
    end
  endtask

  task automatic test_come_out();
    logic [2:0] d1 [4] = '{3'd3, 3'd1, 3'd6, 3'd5};
    logic [2:0] d2 [4] = '{3'd4, 3'd1, 3'd6, 3'd6};
    logic       ew [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      pulse_new_game();
      dice1_in = d1[v]; dice2_in = d2[v];
      press();
      for (int c = 1; c <= 4; c++) begin
        vectors++;
        if ({busy, disp_en} !== 2'b11) begin
          miscompares++;
          $display("FAIL come_out_tumble v%0d c%0d busy/en got %b%b expected 11", v, c, busy, disp_en);
        end
        if (c < 4) tick();
      end
      tick();  // t+5: EVAL
      vectors++;
      if ({busy, disp_en, win, lose, dice1, dice2} !== {4'b1000, d1[v], d2[v]}) begin
        miscompares++;
        $display("FAIL come_out_eval v%0d got busy=%b en=%b win=%b lose=%b d=%0d,%0d expected 1,0,0,0 d=%0d,%0d",
                 v, busy, disp_en, win, lose, dice1, dice2, d1[v], d2[v]);
      end
      tick();  // t+6: outcome
      vectors++;
      if ({busy, win, lose, point} !== {1'b0, ew[v], ~ew[v], 4'd0}) begin
        miscompares++;
        $display("FAIL come_out_result v%0d got busy=%b win=%b lose=%b point=%0d expected 0,%b,%b,0",
                 v, busy, win, lose, point, ew[v], ~ew[v]);
      end
    end
  endtask

  task automatic test_point_made();
    logic [2:0] d1 [3] = '{3'd2, 3'd1, 3'd1};
    logic [2:0] d2 [3] = '{3'd2, 3'd5, 3'd3};
    logic       ew [3] = '{1'b0, 1'b0, 1'b1};
    pulse_new_game();
    for (int v = 0; v < 3; v++) begin
      dice1_in = d1[v]; dice2_in = d2[v];
      press();
      tick(5);
      vectors++;
      if ({busy, win, lose, point} !== {1'b0, ew[v], 1'b0, 4'd4}) begin
        miscompares++;
        $display("FAIL point_made v%0d got busy=%b win=%b lose=%b point=%0d expected 0,%b,0,4",
                 v, busy, win, lose, point, ew[v]);
      end
    end
  endtask

  task automatic test_seven_out();
    pulse_new_game();
    dice1_in = 3'd4; dice2_in = 3'd5;
    press(); tick(5);
    vectors++;
    if (point !== 4'd9) begin
      miscompares++;
      $display("FAIL seven_out_point got %0d expected 9", point);
    end
    dice1_in = 3'd2; dice2_in = 3'd5;
    press(); tick(5);
    vectors++;
    if ({win, lose, point} !== {2'b01, 4'd9}) begin
      miscompares++;
      $display("FAIL seven_out_lose got win=%b lose=%b point=%0d expected 0,1,9", win, lose, point);
    end
    dice1_in = 3'd3; dice2_in = 3'd4;
    press();
    vectors++;
    if ({busy, lose, point} !== {2'b10, 4'd0}) begin
      miscompares++;
      $display("FAIL restart_clear got busy=%b lose=%b point=%0d expected 1,0,0", busy, lose, point);
    end
    tick(5);
    // A 7 only wins in a come-out roll, so this confirms the phase reset.
    vectors++;
    if ({win, lose} !== 2'b10) begin
      miscompares++;
      $display("FAIL restart_come_out got win=%b lose=%b expected 1,0", win, lose);
    end
  endtask

  task automatic test_invalid_die();
    pulse_new_game();
    dice1_in = 3'd2; dice2_in = 3'd3;
    press();
    for (int c = 1; c <= 7; c++) begin
      dice1_in = (c >= 4 && c <= 6) ? 3'd7 : ((c == 7) ? 3'd6 : 3'd2);
      dice2_in = 3'd3;
      roll = (c == 2 || c == 5);
      vectors++;
      if ({busy, disp_en} !== 2'b11) begin
        miscompares++;
        $display("FAIL invalid_tumble c%0d busy/en got %b%b expected 11", c, busy, disp_en);
      end
      tick();
    end
    roll = 1'b0;
    vectors++;
    if ({busy, disp_en, dice1, dice2} !== {2'b10, 3'd6, 3'd3}) begin
      miscompares++;
      $display("FAIL invalid_eval got busy=%b en=%b d=%0d,%0d expected 1,0 d=6,3", busy, disp_en, dice1, dice2);
    end
    tick();
    vectors++;
    if ({busy, win, lose, point} !== {3'b000, 4'd9}) begin
      miscompares++;
      $display("FAIL invalid_result got busy=%b win=%b lose=%b point=%0d expected 0,0,0,9", busy, win, lose, point);
    end
  endtask

  task automatic test_new_game_mid();
    pulse_new_game();
    dice1_in = 3'd3; dice2_in = 3'd4;
    press();
    tick();  // second tumble cycle
    vectors++;
    if ({busy, dice1} !== {1'b1, 3'd3}) begin
      miscompares++;
      $display("FAIL ng_pre got busy=%b dice1=%0d expected 1,3", busy, dice1);
    end
    new_game = 1'b1; roll = 1'b1;
    tick();
    new_game = 1'b0;
    vectors++;
    if ({busy, disp_en, win, lose, point, dice1, dice2} !== 14'd0) begin
      miscompares++;
      $display("FAIL ng_mid got busy=%b en=%b win=%b lose=%b point=%0d d=%0d,%0d expected all 0",
               busy, disp_en, win, lose, point, dice1, dice2);
    end
    tick(3);
    vectors++;
    if ({busy, disp_en} !== 2'b00) begin
      miscompares++;
      $display("FAIL ng_edge_discard busy/en got %b%b expected 00", busy, disp_en);
    end
    roll = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_come_out();
    test_point_made();
    test_seven_out();
    test_invalid_die();
    test_new_game_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/craps_controller.md
# craps_controller

Game sequencer for the craps board. Turns debounced roll-button presses into timed dice "tumbles" and latches the final dice pair. It evaluates the come-out and point rules, then drives the dice values and `clock_en` into the seven-segment display block. It sits between the free-running dice generator and the display, and owns all game state: point, win and lose.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 8: number of tumble cycles before the dice are latched. Must be ≥1.

Ports:
- `clock` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `roll` input 1: debounced roll button, level. Only a rising edge is acted on.
- `new_game` input 1: single-cycle pulse; abandons the current game.
- `dice1_in` input 3: dice generator value, die 1; expected range 1..6.
- `dice2_in` input 3: dice generator value, die 2; expected range 1..6.
- `dice1` output 3: die 1 value to the display.
- `dice2` output 3: die 2 value to the display.
- `disp_en` output 1: display `clock_en`.
- `point` output 4: established point (4,5,6,8,9,10); 0 = no point.
- `win` output 1: game won; held until the next game starts.
- `lose` output 1: game lost; held until the next game starts.
- `busy` output 1: high while tumbling or evaluating.

## Operation

- **Reset values:**
  - State is COME_OUT.
  - `dice1`=`dice2`=0, so the display shows blank.
  - `disp_en`, `point`, `win`, `lose` and `busy` are all 0. The tumble counter is 0.
  - The roll edge-detect register resets to 1, so a button held through reset does not trigger a roll.
- **Roll edge:** `roll`=1 while the registered `roll_q`=0. Edges are ignored in TUMBLE and EVAL.
- **States:**
  - **COME_OUT:** waits for a roll edge, then goes to TUMBLE with phase=come-out.
  - **TUMBLE:**
    - `busy`=1 and `disp_en`=1 on every cycle.
    - `dice1`/`dice2` register `dice1_in`/`dice2_in` every cycle.
    - The counter increments. On the cycle the counter reaches `SETTLE_CYCLES`-1, the sampled inputs are checked:
      - If both dice are in 1..6: latch them, clear the counter, go to EVAL.
      - Otherwise (0 or 7 on either die): stay in TUMBLE and re-check next cycle. The counter holds; there is no limit on extensions.
  - **EVAL** (one cycle, `busy`=1, `disp_en`=0). `sum` = `dice1`+`dice2`, 4-bit, range 2..12.
    - Come-out phase:
      - 7 or 11 → set `win`, go to DONE.
      - 2, 3 or 12 → set `lose`, go to DONE.
      - Any other sum → `point`=`sum`, go to POINT.
    - Point phase:
      - `sum`==`point` → set `win`, go to DONE.
      - `sum`==7 → set `lose`, go to DONE.
      - Any other sum → go to POINT.
      - `point` is unchanged in every point-phase case.
  - **POINT:** waits for a roll edge, then goes to TUMBLE with phase=point.
  - **DONE:**
    - `win`/`lose`, `point` and the dice are held.
    - A roll edge clears `win`, `lose` and `point`, then goes to TUMBLE with phase=come-out.
- **`new_game`:**
  - Valid in any state.
  - Next cycle: state is COME_OUT, `point`/`win`/`lose` are 0, the counter is 0, and `busy`=`disp_en`=0.
  - `dice1`/`dice2` are set to 0, so the display blanks.
- **Simultaneous events:**
  - `new_game` beats a roll edge; the roll edge is discarded.
  - `reset` beats everything.
- **Outputs:** all are registered. `win` and `lose` are never both 1.

## Timing

- Roll edge sampled at cycle t → state TUMBLE and `busy`=1 from t+1.
- `disp_en`=1 for cycles t+1 .. t+`SETTLE_CYCLES`, plus one extra cycle per invalid-die extension.
- EVAL is at t+`SETTLE_CYCLES`+1.
- `win`/`lose`/`point` update and `busy` falls at t+`SETTLE_CYCLES`+2.
- The final `dice1`/`dice2` are stable from t+`SETTLE_CYCLES`+1 until the next tumble or `new_game`.
- A `new_game` pulse at cycle t takes effect at t+1.

## Test plan

All scenarios use `SETTLE_CYCLES`=4.

- **Reset with button held:**
  - Stimulus: assert `reset` with `roll`=1, then release `reset` with `roll` still 1.
  - Response: state stays COME_OUT, `busy`=0, all outputs are 0. A later 0→1 on `roll` starts a tumble.
- **Come-out naturals and craps:**
  - Dice 3,4 → `win`=1, `point`=0, six cycles after the edge.
  - Dice 1,1 → `lose`=1.
  - Dice 6,6 → `lose`=1.
  - Dice 5,6 → `win`=1.
- **Point made:**
  - Come-out 2,2 → `point`=4, `win`=`lose`=0.
  - Roll 1,5 → still in POINT, `point`=4.
  - Roll 1,3 → `win`=1, `point` stays 4.
- **Seven-out and restart:**
  - `point`=9, then roll 2,5 → `lose`=1.
  - Next roll edge → `lose` clears immediately, and a come-out tumble starts.
- **Invalid die and ignored edges:**
  - Hold `dice1_in`=7 over the latch cycle for 3 cycles → `disp_en` stays high for 7 cycles total, and the latched dice are the first valid pair.
  - Roll edges pulsed during TUMBLE have no effect.
- **`new_game` mid-tumble:**
  - Pulse `new_game` during the 2nd TUMBLE cycle, in the same cycle as a roll edge.
  - Next cycle: COME_OUT, `dice1`=`dice2`=0, `busy`=`disp_en`=0, and the roll edge is discarded.
